// File: rtl/br_pkg.sv
// Branch-decode constants shared between the decoder and the branch
// resolve unit.
//   BR_*       3-bit ex_branch encodings (011 is illegal and behaves as none)
//   BHT_RESET  counter value loaded into every BHT entry on reset
package br_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  // weakly not-taken
  localparam logic [1:0] BHT_RESET = 2'b01;

endpackage

// File: rtl/bht_2bit.sv
// Branch history table: ENTRIES x 2-bit saturating counters.
//   clk, rst_n   clock / async active-low reset (all entries -> BHT_RESET)
//   rd_idx       combinational read index
//   rd_ctr       counter at rd_idx; shows the pre-update value during a write
//   upd_en       apply one saturating step to entry upd_idx on this edge
//   upd_idx      update index
//   upd_taken    1 = count up (sat. at 11), 0 = count down (sat. at 00)
module bht_2bit
  import br_pkg::*;
#(
  parameter  int unsigned ENTRIES = 64,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] tbl [ENTRIES];
  logic [1:0] cur;
  logic [1:0] nxt;

  assign rd_ctr = tbl[rd_idx];

  always_comb begin
    cur = tbl[upd_idx];
    nxt = cur;
    if (upd_taken) begin
      if (cur != 2'b11) nxt = cur + 2'd1;
    end else begin
      if (cur != 2'b00) nxt = cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl[i] <= BHT_RESET;
    end else if (upd_en) begin
      tbl[upd_idx] <= nxt;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves EX-stage branches/jumps from raw operands,
// trains a 2-bit BHT read by IF, and registers the redirect result plus
// performance counters.
//   clk, rst_n        clock / async active-low reset
//   pred_pc           IF PC for BHT lookup; pred_taken = MSB of that entry
//   ex_valid, flush   accept = ex_valid & ~flush
//   ex_branch         000 none, 001 jal, 010 jalr, 1xx beq/bne/blt/bge
//   ex_unsigned       selects bltu/bgeu for 110/111
//   ex_rs1, ex_rs2    comparison operands
//   ex_pc             EX PC (BHT update index)
//   ex_pred_taken     prediction that travelled with the instruction
//   res_valid         1 cycle after accept; other res_* hold when not valid
//   pc_a_src          taken; pc_b_src = jalr; res_taken; mispredict
//   perf_branches     accepted non-none instructions (wraps)
//   perf_mispred      accepted mispredicts (wraps)
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pred_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [2:0]        ex_branch,
  input  logic              ex_unsigned,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  input  logic              flush,
  output logic              res_valid,
  output logic              pc_a_src,
  output logic              pc_b_src,
  output logic              res_taken,
  output logic              mispredict,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic       accept;
  logic       is_jal;
  logic       is_jalr;
  logic       is_cond;
  logic       is_ctl;
  logic       eq;
  logic       lt;
  logic       taken;
  logic       mis;
  logic [1:0] rd_ctr;
  logic       lint_unused;

  always_comb begin
    accept  = ex_valid & ~flush;
    is_jal  = (ex_branch == BR_JAL);
    is_jalr = (ex_branch == BR_JALR);
    is_cond = ex_branch[2];
    // 011 falls out of all three, so it behaves exactly like none
    is_ctl  = is_jal | is_jalr | is_cond;
    eq      = (ex_rs1 == ex_rs2);
    lt      = ex_unsigned ? (ex_rs1 < ex_rs2) : ($signed(ex_rs1) < $signed(ex_rs2));
    taken   = 1'b0;
    case (ex_branch)
      BR_JAL, BR_JALR: taken = 1'b1;
      BR_BEQ:          taken = eq;
      BR_BNE:          taken = ~eq;
      BR_BLT:          taken = lt;
      BR_BGE:          taken = ~lt;
      default:         taken = 1'b0;
    endcase
    mis = taken ^ ex_pred_taken;
  end

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (pred_pc[IDX_W+1:2]),
    .rd_ctr    (rd_ctr),
    .upd_en    (accept & is_cond),
    .upd_idx   (ex_pc[IDX_W+1:2]),
    .upd_taken (taken)
  );

  assign pred_taken  = rd_ctr[1];
  assign lint_unused = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                         ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0], rd_ctr[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid     <= 1'b0;
      pc_a_src      <= 1'b0;
      pc_b_src      <= 1'b0;
      res_taken     <= 1'b0;
      mispredict    <= 1'b0;
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else begin
      res_valid <= accept;
      if (accept) begin
        pc_a_src   <= taken;
        pc_b_src   <= is_jalr;
        res_taken  <= taken;
        mispredict <= mis;
        if (is_ctl) perf_branches <= perf_branches + PERF_W'(1);
        if (mis)    perf_mispred  <= perf_mispred + PERF_W'(1);
      end
    end
  end

endmodule
